// File: rtl/ln_residual_pack.sv
// Residual add (in_a + in_b, 16-bit saturating) packed into a SEQ_LEN x EMB_DIM frame for layer-norm.
// Optional macro LN_RESIDUAL_SAT_COUNT_EN enables the saturation event counter on sat_cnt.
`timescale 1ns/1ps
module ln_residual_pack #(
  parameter int DATA_WIDTH = 16,
  parameter int SEQ_LEN    = 16,
  parameter int EMB_DIM    = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [DATA_WIDTH-1:0]                 in_a,
  input  logic [DATA_WIDTH-1:0]                 in_b,
  input  logic                                  flush,
  output logic                                  ln_start,
  input  logic                                  ln_done,
  output logic [DATA_WIDTH*SEQ_LEN*EMB_DIM-1:0] x_flat,
  output logic                                  busy,
  output logic [15:0]                           sat_cnt
);

  localparam int DEPTH  = SEQ_LEN * EMB_DIM;
  localparam int FLAT_W = DATA_WIDTH * DEPTH;
  localparam int ROW_W  = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int COL_W  = (EMB_DIM > 1) ? $clog2(EMB_DIM) : 1;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_START, S_WAIT} state_t;

  state_t              state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [FLAT_W-1:0]   x_q, x_d;
  logic [IDX_W-1:0]    slot;
  logic [DATA_WIDTH:0] sum_ext;
  logic [DATA_WIDTH-1:0] sum_sat;
  logic                ovf;
  logic                fire;
  logic                last_row, last_col;

  // 17-bit sum overflows 16 bits exactly when its top two bits disagree.
  always_comb begin
    sum_ext = {in_a[DATA_WIDTH-1], in_a} + {in_b[DATA_WIDTH-1], in_b};
    ovf     = sum_ext[DATA_WIDTH] ^ sum_ext[DATA_WIDTH-1];
    if (!ovf) begin
      sum_sat = sum_ext[DATA_WIDTH-1:0];
    end else if (sum_ext[DATA_WIDTH]) begin
      sum_sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      sum_sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end

  assign last_row = (row_q == ROW_W'(SEQ_LEN - 1));
  assign last_col = (col_q == COL_W'(EMB_DIM - 1));
  assign slot     = IDX_W'(row_q) * IDX_W'(EMB_DIM) + IDX_W'(col_q);

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    x_d      = x_q;
    in_ready = 1'b0;
    ln_start = 1'b0;
    busy     = 1'b0;
    fire     = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FILL;
      S_FILL: begin
        in_ready = 1'b1;
        if (flush) begin
          row_d = '0;
          col_d = '0;
        end else if (in_valid) begin
          fire = 1'b1;
          if (last_col) begin
            col_d = '0;
            if (last_row) begin
              row_d   = '0;
              state_d = S_START;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_START: begin
        ln_start = 1'b1;
        busy     = 1'b1;
        row_d    = '0;
        col_d    = '0;
        state_d  = flush ? S_FILL : S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (flush || ln_done) begin
          row_d   = '0;
          col_d   = '0;
          state_d = S_FILL;
        end
      end
      default: state_d = S_IDLE;
    endcase
    for (int i = 0; i < DEPTH; i++) begin
      if (fire && (slot == IDX_W'(i))) begin
        x_d[i*DATA_WIDTH +: DATA_WIDTH] = sum_sat;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      x_q     <= x_d;
    end
  end

  assign x_flat = x_q;

`ifdef LN_RESIDUAL_SAT_COUNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;

  // A new frame after the wait starts a fresh count; a flush mid-fill does not.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if ((state_q == S_WAIT) && (state_d == S_FILL)) begin
      sat_cnt_d = '0;
    end else if (fire && ovf && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_d = sat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_cnt = sat_cnt_q;
`else
  assign sat_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_ln_residual_pack.sv
// Bench for ln_residual_pack: a 2x4 instance for directed scenarios and a 16x32 instance for random fill.
`timescale 1ns/1ps
module tb_ln_residual_pack;
  localparam int W  = 16;
  localparam int NS = 8;
  localparam int NL = 512;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid_s, in_ready_s, flush_s, ln_start_s, ln_done_s, busy_s;
  logic [W-1:0]  in_a_s, in_b_s;
  logic [15:0]   sat_cnt_s;
  logic [W*NS-1:0] x_s;

  logic          in_valid_l, in_ready_l, flush_l, ln_start_l, ln_done_l, busy_l;
  logic [W-1:0]  in_a_l, in_b_l;
  logic [15:0]   sat_cnt_l;
  logic [W*NL-1:0] x_l;

  ln_residual_pack #(.DATA_WIDTH(W), .SEQ_LEN(2), .EMB_DIM(4)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .in_a(in_a_s), .in_b(in_b_s), .flush(flush_s), .ln_start(ln_start_s),
    .ln_done(ln_done_s), .x_flat(x_s), .busy(busy_s), .sat_cnt(sat_cnt_s)
  );

  ln_residual_pack #(.DATA_WIDTH(W), .SEQ_LEN(16), .EMB_DIM(32)) dut_l (
    .clk(clk), .rst(rst), .in_valid(in_valid_l), .in_ready(in_ready_l),
    .in_a(in_a_l), .in_b(in_b_l), .flush(flush_l), .ln_start(ln_start_l),
    .ln_done(ln_done_l), .x_flat(x_l), .busy(busy_l), .sat_cnt(sat_cnt_l)
  );

  int tests = 0;
  int fails = 0;

  // reference model: slot contents, write pointer, clamp count, expected frames
  logic [W-1:0]    mdl_s[NS];
  logic [W-1:0]    mdl_l[NL];
  int              p_s, p_l, sat_m_s, sat_m_l, starts_s, starts_l;
  logic [W*NS-1:0] exp_q_s[$];
  logic [W*NL-1:0] exp_q_l[$];
  logic [W*NS-1:0] e_s;
  logic [W*NL-1:0] e_l, last_l;

  function automatic logic [W-1:0] res(input logic [W-1:0] a, input logic [W-1:0] b,
                                       output bit clamped);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    clamped = 1'b0;
    if (s > 32767) begin s = 32767; clamped = 1'b1; end
    else if (s < -32768) begin s = -32768; clamped = 1'b1; end
    return W'(s);
  endfunction

  function automatic int sat_exp(input int m);
`ifdef LN_RESIDUAL_SAT_COUNT_EN
    return (m > 65535) ? 65535 : m;
`else
    return 0 * m;
`endif
  endfunction

  function automatic logic [W*NS-1:0] pack_s();
    logic [W*NS-1:0] v;
    for (int i = 0; i < NS; i++) v[i*W +: W] = mdl_s[i];
    return v;
  endfunction

  function automatic logic [W*NL-1:0] pack_l();
    logic [W*NL-1:0] v;
    for (int i = 0; i < NL; i++) v[i*W +: W] = mdl_l[i];
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks: present an element, wait for in_ready, then let one edge consume it
  task automatic send_s(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    bit c;
    n = 0;
    in_valid_s = 1'b1; in_a_s = a; in_b_s = b;
    while (!in_ready_s && n < 200) begin @(posedge clk); #1; n++; end
    if (!in_ready_s) begin
      tests++; fails++;
      $display("FAIL send_s_timeout: in_ready stayed %0b required 1", in_ready_s);
      in_valid_s = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid_s = 1'b0;
    mdl_s[p_s] = res(a, b, c);
    if (c) sat_m_s++;
    p_s++;
    if (p_s == NS) begin exp_q_s.push_back(pack_s()); p_s = 0; end
  endtask

  task automatic send_l(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    bit c;
    n = 0;
    in_valid_l = 1'b1; in_a_l = a; in_b_l = b;
    while (!in_ready_l && n < 200) begin @(posedge clk); #1; n++; end
    if (!in_ready_l) begin
      tests++; fails++;
      $display("FAIL send_l_timeout: in_ready stayed %0b required 1", in_ready_l);
      in_valid_l = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid_l = 1'b0;
    mdl_l[p_l] = res(a, b, c);
    if (c) sat_m_l++;
    p_l++;
    if (p_l == NL) begin last_l = pack_l(); exp_q_l.push_back(last_l); p_l = 0; end
  endtask

  task automatic done_s();
    @(posedge clk); #1; ln_done_s = 1'b1;
    @(posedge clk); #1; ln_done_s = 1'b0;
    sat_m_s = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // scoreboard monitors: each ln_start pops and checks one expected frame
  always @(negedge clk) begin
    if (!rst && ln_start_s) begin
      starts_s++;
      tests++;
      if (exp_q_s.size() == 0) begin
        fails++;
        $display("FAIL start_s_unexpected: ln_start=1 with no frame expected");
      end else begin
        e_s = exp_q_s.pop_front();
        if (x_s !== e_s) begin
          fails++;
          for (int i = 0; i < NS; i++)
            if (x_s[i*W +: W] !== e_s[i*W +: W]) begin
              $display("FAIL frame_s slot %0d: got %0h expected %0h", i, x_s[i*W +: W], e_s[i*W +: W]);
              break;
            end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ln_start_l) begin
      starts_l++;
      tests++;
      if (exp_q_l.size() == 0) begin
        fails++;
        $display("FAIL start_l_unexpected: ln_start=1 with no frame expected");
      end else begin
        e_l = exp_q_l.pop_front();
        if (x_l !== e_l) begin
          fails++;
          for (int i = 0; i < NL; i++)
            if (x_l[i*W +: W] !== e_l[i*W +: W]) begin
              $display("FAIL frame_l slot %0d: got %0h expected %0h", i, x_l[i*W +: W], e_l[i*W +: W]);
              break;
            end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    int st;
    rst = 1'b1;
    in_valid_s = 0; in_a_s = 0; in_b_s = 0; flush_s = 0; ln_done_s = 0;
    in_valid_l = 0; in_a_l = 0; in_b_l = 0; flush_l = 0; ln_done_l = 0;
    p_s = 0; p_l = 0; sat_m_s = 0; sat_m_l = 0; starts_s = 0; starts_l = 0;
    for (int i = 0; i < NS; i++) mdl_s[i] = '0;
    for (int i = 0; i < NL; i++) mdl_l[i] = '0;
    #22;
    check("rst_x_flat_s", 64'(x_s == '0), 1);
    check("rst_x_flat_l", 64'(x_l == '0), 1);
    check("rst_in_ready", in_ready_s, 0);
    check("rst_busy", busy_s, 0);
    check("rst_ln_start", ln_start_s, 0);
    check("rst_sat_cnt", sat_cnt_s, 0);
    @(negedge clk); rst = 1'b0; #1;
    check("rel_in_ready", in_ready_s, 0);
    idle(2);
    check("ready_two_edges", in_ready_s, 1);

    // fill: in_a=k, in_b=10k back to back
    for (int k = 0; k < NS; k++) send_s(W'(k), W'(10 * k));
    check("fill_ln_start", ln_start_s, 1);
    check("fill_busy_start", busy_s, 1);
    for (int k = 0; k < NS; k++) check("fill_slot", x_s[k*W +: W], 11 * k);
    idle(1);
    check("wait_ln_start_low", ln_start_s, 0);
    check("wait_busy", busy_s, 1);
    check("wait_in_ready", in_ready_s, 0);

    // element held valid during wait lands in slot 0 only after ln_done
    fork
      send_s(16'd5, 16'd6);
      begin
        idle(5);
        check("wait_frozen_slot0", x_s[0 +: W], 0);
        check("wait_still_busy", busy_s, 1);
        ln_done_s = 1'b1;
        idle(1);
        ln_done_s = 1'b0;
        sat_m_s = 0;
      end
    join
    check("wait_elem_slot0", x_s[0 +: W], 11);
    check("old_slot1_kept", x_s[W +: W], 11);

    // saturation in both directions
    send_s(16'h7000, 16'h2000);
    send_s(16'h8000, 16'hFFFF);
    for (int k = 0; k < 5; k++) send_s(W'($urandom_range(0, 2000)), W'($urandom_range(0, 2000)));
    check("sat_pos_slot", x_s[1*W +: W], 16'h7FFF);
    check("sat_neg_slot", x_s[2*W +: W], 16'h8000);
    check("sat_cnt_two", sat_cnt_s, sat_exp(2));
    check("sat_cnt_model", sat_cnt_s, sat_exp(sat_m_s));
    done_s();

    // random gaps, full-range data
    for (int k = 0; k < NS; k++) begin
      idle($urandom_range(0, 3));
      send_s(W'($urandom), W'($urandom));
    end
    check("gaps_sat_cnt", sat_cnt_s, sat_exp(sat_m_s));
    done_s();

    // flush in fill after 5 fires, with an element presented that cycle
    st = starts_s;
    for (int k = 0; k < 5; k++) send_s(W'($urandom), W'($urandom));
    flush_s = 1'b1; in_valid_s = 1'b1; in_a_s = 16'h1234; in_b_s = 16'h0101;
    idle(1);
    flush_s = 1'b0; in_valid_s = 1'b0;
    p_s = 0;
    check("flush_drop_slot5", x_s[5*W +: W], mdl_s[5]);
    check("flush_no_start", starts_s, st);
    for (int k = 0; k < NS; k++) send_s(W'(100 + k), W'($urandom_range(0, 50)));
    check("flush_sat_kept", sat_cnt_s, sat_exp(sat_m_s));
    done_s();
    check("flush_one_start", starts_s, st + 1);

    // flush and ln_done together in wait
    for (int k = 0; k < NS; k++) send_s(W'($urandom), W'($urandom));
    idle(1);
    flush_s = 1'b1; ln_done_s = 1'b1;
    idle(1);
    flush_s = 1'b0; ln_done_s = 1'b0;
    sat_m_s = 0;
    check("flush_wait_ready", in_ready_s, 1);
    check("flush_wait_sat_clr", sat_cnt_s, sat_exp(sat_m_s));

    // asynchronous reset mid-frame
    for (int k = 0; k < 3; k++) send_s(W'(k + 1), W'(k + 1));
    #2 rst = 1'b1; #1;
    check("midrst_x_flat", 64'(x_s == '0), 1);
    check("midrst_in_ready", in_ready_s, 0);
    check("midrst_busy", busy_s, 0);
    p_s = 0; sat_m_s = 0;
    for (int i = 0; i < NS; i++) mdl_s[i] = '0;
    @(negedge clk); rst = 1'b0; #1;
    idle(2);
    check("midrst_ready", in_ready_s, 1);
    st = starts_s;
    for (int k = 0; k < NS; k++) send_s(W'(k), W'(10 * k));
    check("refill_ln_start", ln_start_s, 1);
    done_s();
    check("refill_one_start", starts_s, st + 1);

    // default geometry: 512 random elements
    for (int i = 0; i < NL; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send_l(W'($urandom), W'($urandom));
    end
    check("big_ln_start", ln_start_l, 1);
    check("big_sat_cnt", sat_cnt_l, sat_exp(sat_m_l));
    in_valid_l = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_a_l = W'($urandom); in_b_l = W'($urandom);
      idle(1);
    end
    in_valid_l = 1'b0;
    check("big_no_write_after", 64'(x_l === last_l), 1);
    check("big_busy", busy_l, 1);
    check("big_one_start", starts_l, 1);

    check("exp_q_s_empty", exp_q_s.size(), 0);
    check("exp_q_l_empty", exp_q_l.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
